// File: rtl/wfs_pkg.sv
// wfs_pkg: shared types for the word fetch sequencer.
// Fixed state encoding and wait-state counter width.
package wfs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    FIN  = 2'd3
  } wfs_state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/word_fetch_sequencer_counter.sv
// wait_state_counter: per-byte wait-state down counter.
// Load has priority, decrement saturates at zero.
module wait_state_counter
  import wfs_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // load, count down while nonzero, else hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/word_fetch_sequencer.sv
// word_fetch_sequencer: two byte reads -> one 16-bit word.
// Optional bus stall input under WFS_BUS_WAIT_EN.
module word_fetch_sequencer
  import wfs_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] addr,
`ifdef WFS_BUS_WAIT_EN
  input  logic              bus_wait,
`endif
  output logic              busy,
  output logic              done,
  output logic              bus_rd,
  output logic [ADDR_W:0]   byte_addr,
  output logic              en0,
  output logic              en1,
  output logic              ld,
  output logic              clr
);

  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

  wfs_state_t        state_q;
  wfs_state_t        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              sel_q;
  logic              sel_d;
  logic              busy_d;
  logic              done_d;
  logic              rd_d;
  logic              en0_d;
  logic              en1_d;
  logic              ld_d;
  logic              clr_d;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt;
  logic              zero;
  logic              ready;

`ifdef WFS_BUS_WAIT_EN
  assign ready = ~bus_wait;
`else
  assign ready = 1'b1;
`endif

  wait_state_counter u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (WS),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (zero)
  );

  // state, latched address and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bus_rd  <= 1'b0;
      en0     <= 1'b0;
      en1     <= 1'b0;
      ld      <= 1'b0;
      clr     <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      busy    <= busy_d;
      done    <= done_d;
      bus_rd  <= rd_d;
      en0     <= en0_d;
      en1     <= en1_d;
      ld      <= ld_d;
      clr     <= clr_d;
    end
  end

  // next state; strobes are set one cycle ahead so they register
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    rd_d     = 1'b0;
    en0_d    = 1'b0;
    en1_d    = 1'b0;
    ld_d     = 1'b0;
    clr_d    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      clr_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = LO;
            addr_d   = addr;
            sel_d    = 1'b0;
            cnt_load = 1'b1;
            busy_d   = 1'b1;
            rd_d     = 1'b1;
            en0_d    = (WS == '0) && ready;
          end
        end
        LO: begin
          busy_d = 1'b1;
          rd_d   = 1'b1;
          if (!zero) begin
            cnt_dec = 1'b1;
            en0_d   = (cnt == CNT_W'(1)) && ready;
          end else if (en0) begin
            state_d  = HI;
            sel_d    = 1'b1;
            cnt_load = 1'b1;
            en1_d    = (WS == '0) && ready;
            ld_d     = (WS == '0) && ready;
          end else begin
            en0_d = ready;
          end
        end
        HI: begin
          busy_d = 1'b1;
          rd_d   = 1'b1;
          if (!zero) begin
            cnt_dec = 1'b1;
            en1_d   = (cnt == CNT_W'(1)) && ready;
            ld_d    = (cnt == CNT_W'(1)) && ready;
          end else if (en1) begin
            state_d = FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            rd_d    = 1'b0;
          end else begin
            en1_d = ready;
            ld_d  = ready;
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign byte_addr = {addr_q, sel_q};

endmodule

// File: tb/tb_word_fetch_sequencer.sv
// tb_word_fetch_sequencer: directed vectors for W=2 and W=0
// instances plus an async reset sequence.
module tb_word_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] addr = '0;
  logic        bus_wait = 1'b0;

  logic        w2_busy, w2_done, w2_rd, w2_en0, w2_en1, w2_ld, w2_clr;
  logic [16:0] w2_ba;
  logic        w0_busy, w0_done, w0_rd, w0_en0, w0_en1, w0_ld, w0_clr;
  logic [16:0] w0_ba;

  logic [23:0] v2, v0;
  assign v2 = {w2_busy, w2_done, w2_rd, w2_en0, w2_en1, w2_ld, w2_clr, w2_ba};
  assign v0 = {w0_busy, w0_done, w0_rd, w0_en0, w0_en1, w0_ld, w0_clr, w0_ba};

  always #5 clk = ~clk;

  word_fetch_sequencer #(.ADDR_W(16), .WAIT_STATES(2)) u_w2 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .addr(addr),
`ifdef WFS_BUS_WAIT_EN
    .bus_wait(bus_wait),
`endif
    .busy(w2_busy), .done(w2_done), .bus_rd(w2_rd), .byte_addr(w2_ba),
    .en0(w2_en0), .en1(w2_en1), .ld(w2_ld), .clr(w2_clr)
  );

  word_fetch_sequencer #(.ADDR_W(16), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .addr(addr),
`ifdef WFS_BUS_WAIT_EN
    .bus_wait(bus_wait),
`endif
    .busy(w0_busy), .done(w0_done), .bus_rd(w0_rd), .byte_addr(w0_ba),
    .en0(w0_en0), .en1(w0_en1), .ld(w0_ld), .clr(w0_clr)
  );

  // byte bus memory and word synchronizer model for the W=2 instance
  logic [7:0]  d;
  logic [7:0]  lo_b, hi_b;
  logic [15:0] q;
  assign d = w2_ba[0] ? 8'h5A : 8'hA5;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_b <= '0;
      hi_b <= '0;
      q    <= '0;
    end else begin
      if (w2_en0) lo_b <= d;
      if (w2_en1) hi_b <= d;
      if (w2_ld)  q <= {(w2_en1 ? d : hi_b), lo_b};
    end
  end

  typedef struct {
    bit          first;
    bit          w0;
    logic        start;
    logic        abort;
    logic [15:0] addr;
    logic [23:0] exp;
    bit          chkq;
    logic [15:0] expq;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input bit first, input bit w0, input logic st,
                     input logic ab, input logic [15:0] ad,
                     input logic [6:0] f, input logic [16:0] ba,
                     input string name);
    vec_t v;
    v.first = first; v.w0 = w0; v.start = st; v.abort = ab;
    v.addr = ad; v.exp = {f, ba}; v.chkq = 1'b0; v.expq = '0;
    v.name = name;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    addr = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [23:0] act,
                       input logic [23:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // flag order: busy done rd en0 en1 ld clr
  initial begin
    // W=2 fetch of word 1234
    add(1, 0, 1, 0, 16'h1234, 7'b0000000, 17'h00000, "t2 c0");
    add(0, 0, 0, 0, 16'h1234, 7'b1010000, 17'h02468, "t2 c1");
    add(0, 0, 0, 0, 16'h1234, 7'b1010000, 17'h02468, "t2 c2");
    add(0, 0, 0, 0, 16'h1234, 7'b1011000, 17'h02468, "t2 c3 en0");
    add(0, 0, 0, 0, 16'h1234, 7'b1010000, 17'h02469, "t2 c4");
    add(0, 0, 0, 0, 16'h1234, 7'b1010000, 17'h02469, "t2 c5");
    add(0, 0, 0, 0, 16'h1234, 7'b1010110, 17'h02469, "t2 c6 en1 ld");
    add(0, 0, 0, 0, 16'h1234, 7'b0100000, 17'h02469, "t2 c7 done");
    add(0, 0, 0, 0, 16'h1234, 7'b0000000, 17'h02469, "t2 c8 idle");
    vecs[$].chkq = 1'b1;
    vecs[$].expq = 16'h5AA5;
    // W=0 back-to-back, START held through FIN
    add(1, 1, 1, 0, 16'h0000, 7'b0000000, 17'h00000, "t3 c0");
    add(0, 1, 1, 0, 16'h0001, 7'b1011000, 17'h00000, "t3 c1 en0");
    add(0, 1, 1, 0, 16'h0001, 7'b1010110, 17'h00001, "t3 c2 en1 ld");
    add(0, 1, 1, 0, 16'h0001, 7'b0100000, 17'h00001, "t3 c3 done");
    add(0, 1, 1, 0, 16'h0001, 7'b0000000, 17'h00001, "t3 c4 idle");
    add(0, 1, 0, 0, 16'h0001, 7'b1011000, 17'h00002, "t3 c5 en0");
    add(0, 1, 0, 0, 16'h0001, 7'b1010110, 17'h00003, "t3 c6 en1 ld");
    add(0, 1, 0, 0, 16'h0001, 7'b0100000, 17'h00003, "t3 c7 done");
    add(0, 1, 0, 0, 16'h0001, 7'b0000000, 17'h00003, "t3 c8 idle");
    // W=2 abort in HI, then ABORT+START in IDLE
    add(1, 0, 1, 0, 16'h1234, 7'b0000000, 17'h00000, "t4 c0");
    add(0, 0, 0, 0, 16'h1234, 7'b1010000, 17'h02468, "t4 c1");
    add(0, 0, 0, 0, 16'h1234, 7'b1010000, 17'h02468, "t4 c2");
    add(0, 0, 0, 0, 16'h1234, 7'b1011000, 17'h02468, "t4 c3 en0");
    add(0, 0, 0, 1, 16'h1234, 7'b1010000, 17'h02469, "t4 c4");
    add(0, 0, 0, 0, 16'h1234, 7'b0000001, 17'h02469, "t4 c5 clr");
    add(0, 0, 1, 1, 16'h1234, 7'b0000000, 17'h02469, "t4 c6 idle");
    add(0, 0, 0, 0, 16'h1234, 7'b0000001, 17'h02469, "t4 c7 clr only");
    add(0, 0, 0, 0, 16'h1234, 7'b0000000, 17'h02469, "t4 c8 idle");
    // W=2 address changes after acceptance
    add(1, 0, 1, 0, 16'h00FF, 7'b0000000, 17'h00000, "t6 c0");
    add(0, 0, 0, 0, 16'hFFFF, 7'b1010000, 17'h001FE, "t6 c1");
    add(0, 0, 0, 0, 16'hFFFF, 7'b1010000, 17'h001FE, "t6 c2");
    add(0, 0, 0, 0, 16'hFFFF, 7'b1011000, 17'h001FE, "t6 c3 en0");
    add(0, 0, 0, 0, 16'hFFFF, 7'b1010000, 17'h001FF, "t6 c4 hi");
    add(0, 0, 0, 0, 16'hFFFF, 7'b1010000, 17'h001FF, "t6 c5");
    add(0, 0, 0, 0, 16'hFFFF, 7'b1010110, 17'h001FF, "t6 c6 en1 ld");
    add(0, 0, 0, 0, 16'hFFFF, 7'b0100000, 17'h001FF, "t6 c7 done");
    // W=0 max address
    add(1, 1, 1, 0, 16'hFFFF, 7'b0000000, 17'h00000, "t6b c0");
    add(0, 1, 0, 0, 16'hFFFF, 7'b1011000, 17'h1FFFE, "t6b c1 en0");
    add(0, 1, 0, 0, 16'hFFFF, 7'b1010110, 17'h1FFFF, "t6b c2 max");
    add(0, 1, 0, 0, 16'hFFFF, 7'b0100000, 17'h1FFFF, "t6b c3 done");

    foreach (vecs[i]) begin
      if (vecs[i].first) do_reset();
      check(vecs[i].name, vecs[i].w0 ? v0 : v2, vecs[i].exp);
      if (vecs[i].chkq) begin
        tests++;
        if (q !== vecs[i].expq) begin
          fails++;
          $display("FAIL %s q: got %h expected %h",
                   vecs[i].name, q, vecs[i].expq);
        end
      end
      start = vecs[i].start;
      abort = vecs[i].abort;
      addr  = vecs[i].addr;
      @(posedge clk); #1;
    end

    // async reset in the middle of HI
    do_reset();
    start = 1'b1;
    addr  = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("t1 mid-HI busy", v2, {7'b1010000, 17'h02469});
    #2;
    reset_n = 1'b0;
    #1;
    check("t1 async reset", v2, 24'h000000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("t1 idle after release", v2, 24'h000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
